// File: rtl/obstacle_scroller_if.sv
// Obstacle-scroller port bundle: selector handshake, game control and
// the position/visibility/scoring outputs seen by renderer and collision logic.
interface obstacle_scroller_if;
  logic [1:0]         gamestate;
  logic               tick;
  logic [3:0]         sel_in;
  logic [9:0]         width_in;
  logic               obstacle_req;
  logic signed [11:0] obstacle_x;
  logic [9:0]         obstacle_w;
  logic [3:0]         obstacle_sel;
  logic               obstacle_visible;
  logic               passed;
  logic [3:0]         speed;

  modport master (
    input  gamestate, tick, sel_in, width_in,
    output obstacle_req, obstacle_x, obstacle_w, obstacle_sel,
           obstacle_visible, passed, speed
  );

  modport slave (
    output gamestate, tick, sel_in, width_in,
    input  obstacle_req, obstacle_x, obstacle_w, obstacle_sel,
           obstacle_visible, passed, speed
  );
endinterface

// File: rtl/obstacle_scroller.sv
// Requests an obstacle from the selector, latches it, scrolls it left one
// speed step per frame tick, then waits a gap before requesting the next.
module obstacle_scroller #(
  parameter int SCREEN_W   = 640,
  parameter int GAP_TICKS  = 60,
  parameter int REQ_HOLD   = 2,
  parameter int SPEED_INIT = 4,
  parameter int SPEED_MAX  = 12,
  parameter int SPEED_STEP = 5
) (
  input  logic clk,
  input  logic rst,
  obstacle_scroller_if.master bus
);

  localparam int HOLD_W = (REQ_HOLD   > 1) ? $clog2(REQ_HOLD)   : 1;
  localparam int GAP_W  = (GAP_TICKS  > 1) ? $clog2(GAP_TICKS)  : 1;
  localparam int PASS_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(REQ_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_TICKS - 1);
  localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'(SPEED_STEP - 1);
  localparam logic signed [11:0] SPAWN_X   = 12'(SCREEN_W);
  localparam logic [3:0]        SPEED_RST  = 4'(SPEED_INIT);
  localparam logic [3:0]        SPEED_CEIL = 4'(SPEED_MAX);

  typedef enum logic [2:0] {
    IDLE, REQ, LATCH, MOVE, GAP, FROZEN
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic signed [11:0] x_q, x_d;
  logic [9:0]         w_q, w_d;
  logic [3:0]         sel_q, sel_d;
  logic               vis_q, vis_d;
  logic               passed_q, passed_d;
  logic [3:0]         speed_q, speed_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PASS_W-1:0]  pass_q, pass_d;

  logic signed [11:0] x_step;
  logic signed [12:0] right_edge;
  logic [3:0]         speed_inc;

  always_comb begin
    x_step     = x_q - $signed({8'd0, speed_q});
    // One extra bit so a 1023-pixel width cannot wrap the exit test.
    right_edge = $signed({x_step[11], x_step}) + $signed({3'b000, w_q});
    speed_inc  = (speed_q >= SPEED_CEIL) ? speed_q : speed_q + 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    x_d      = x_q;
    w_d      = w_q;
    sel_d    = sel_q;
    vis_d    = vis_q;
    passed_d = 1'b0;
    speed_d  = speed_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    pass_d   = pass_q;

    if (bus.gamestate[1]) begin
      state_d = FROZEN;
      req_d   = 1'b0;
    end else if (bus.gamestate == 2'b00) begin
      state_d = IDLE;
      req_d   = 1'b0;
      x_d     = SPAWN_X;
      vis_d   = 1'b0;
      speed_d = SPEED_RST;
      hold_d  = '0;
      gap_d   = '0;
      pass_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          req_d   = 1'b1;
          hold_d  = '0;
        end
        REQ: begin
          // The capture is registered on entry to LATCH so the LATCH cycle
          // already shows the new obstacle with the request dropped.
          if (hold_q == HOLD_LAST) begin
            state_d = LATCH;
            req_d   = 1'b0;
            sel_d   = bus.sel_in;
            w_d     = bus.width_in;
            x_d     = SPAWN_X;
            vis_d   = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        LATCH: state_d = MOVE;
        MOVE: begin
          if (bus.tick) begin
            x_d = x_step;
            if (right_edge <= 13'sd0) begin
              state_d  = GAP;
              vis_d    = 1'b0;
              passed_d = 1'b1;
              if (pass_q == PASS_LAST) begin
                pass_d  = '0;
                speed_d = speed_inc;
              end else begin
                pass_d = pass_q + 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (bus.tick) begin
            if (gap_q == GAP_LAST) begin
              gap_d   = '0;
              state_d = REQ;
              req_d   = 1'b1;
              hold_d  = '0;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
        FROZEN: req_d = 1'b0;
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      x_q      <= SPAWN_X;
      w_q      <= '0;
      sel_q    <= '0;
      vis_q    <= 1'b0;
      passed_q <= 1'b0;
      speed_q  <= SPEED_RST;
      hold_q   <= '0;
      gap_q    <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      x_q      <= x_d;
      w_q      <= w_d;
      sel_q    <= sel_d;
      vis_q    <= vis_d;
      passed_q <= passed_d;
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.obstacle_req     = req_q;
  assign bus.obstacle_x       = x_q;
  assign bus.obstacle_w       = w_q;
  assign bus.obstacle_sel     = sel_q;
  assign bus.obstacle_visible = vis_q;
  assign bus.passed           = passed_q;
  assign bus.speed            = speed_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scenario bench for obstacle_scroller: a default instance plus one with the
// speed ceiling lowered to 5, both driven with identical stimulus.
module tb_obstacle_scroller;

  localparam int SCREEN_W  = 640;
  localparam int GAP_TICKS = 60;

  logic clk = 1'b0;
  logic rst;

  obstacle_scroller_if bus ();
  obstacle_scroller_if bus2 ();

  assign bus2.gamestate = bus.gamestate;
  assign bus2.tick      = bus.tick;
  assign bus2.sel_in    = bus.sel_in;
  assign bus2.width_in  = bus.width_in;

  obstacle_scroller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  obstacle_scroller #(.SPEED_MAX(5)) dut_cap (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] esel;
    logic [9:0] ew;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_speed, exp_cnt, exp_speed2, exp_cnt2;

  // Reference speed stepping: +1 every 5 passes, clamped at each instance's ceiling.
  task automatic model_pass();
    exp_cnt++;
    if (exp_cnt == 5) begin
      exp_cnt = 0;
      if (exp_speed < 12) exp_speed++;
    end
    exp_cnt2++;
    if (exp_cnt2 == 5) begin
      exp_cnt2 = 0;
      if (exp_speed2 < 5) exp_speed2++;
    end
  endtask

  // One obstacle: wait for request, serve it, scroll to exit, then time the gap.
  // A non-negative stop_x returns once the obstacle reaches that x.
  task automatic do_obstacle(input logic [3:0] s, input logic [9:0] w,
                             input int stop_x, output int ticks, output int last_x);
    int   n;
    int   x_m;
    bit   hit;
    obs_t e;
    ticks  = 0;
    last_x = SCREEN_W;
    n = 0;
    while (bus.obstacle_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.obstacle_req !== 1'b1) begin
      errors++;
      $display("FAIL req_wait: obstacle_req=%b required 1 within 300 cycles", bus.obstacle_req);
      return;
    end
    bus.sel_in   = s;
    bus.width_in = w;
    sb_q.push_back('{esel: s, ew: w});
    @(negedge clk);
    checks++;
    if (bus.obstacle_req !== 1'b1) begin
      errors++;
      $display("FAIL req_hold: obstacle_req=%b required 1 in second request cycle", bus.obstacle_req);
    end
    @(negedge clk);
    checks++;
    if (bus.obstacle_req !== 1'b0 || bus.obstacle_visible !== 1'b1) begin
      errors++;
      $display("FAIL latch_cycle: req=%b visible=%b required req=0 visible=1",
               bus.obstacle_req, bus.obstacle_visible);
    end
    e = sb_q.pop_front();
    checks++;
    if (bus.obstacle_sel !== e.esel || bus.obstacle_w !== e.ew || bus.obstacle_x !== 12'(SCREEN_W)) begin
      errors++;
      $display("FAIL latch_fields: sel=%b w=%0d x=%0d required sel=%b w=%0d x=%0d",
               bus.obstacle_sel, bus.obstacle_w, $signed(bus.obstacle_x), e.esel, e.ew, SCREEN_W);
    end
    checks++;
    if (bus.speed !== 4'(exp_speed) || bus2.speed !== 4'(exp_speed2)) begin
      errors++;
      $display("FAIL speed_latch: speed=%0d capped=%0d required %0d and %0d",
               bus.speed, bus2.speed, exp_speed, exp_speed2);
    end
    @(negedge clk);
    checks++;
    if (bus.obstacle_x !== 12'(SCREEN_W)) begin
      errors++;
      $display("FAIL latch_tick_ignored: x=%0d required %0d", $signed(bus.obstacle_x), SCREEN_W);
    end
    x_m = SCREEN_W;
    hit = 1'b0;
    for (int t = 0; t < 1000 && !hit; t++) begin
      @(negedge clk);
      x_m = x_m - exp_speed;
      ticks++;
      checks++;
      if (x_m + int'(w) <= 0) begin
        hit = 1'b1;
        if (bus.obstacle_x !== 12'(x_m) || bus.passed !== 1'b1 || bus.obstacle_visible !== 1'b0) begin
          errors++;
          $display("FAIL exit: x=%0d passed=%b visible=%b required x=%0d passed=1 visible=0",
                   $signed(bus.obstacle_x), bus.passed, bus.obstacle_visible, x_m);
        end
      end else begin
        if (bus.obstacle_x !== 12'(x_m) || bus.passed !== 1'b0 || bus.obstacle_visible !== 1'b1) begin
          errors++;
          $display("FAIL scroll: x=%0d passed=%b visible=%b required x=%0d passed=0 visible=1",
                   $signed(bus.obstacle_x), bus.passed, bus.obstacle_visible, x_m);
        end
        if (stop_x >= 0 && x_m <= stop_x) begin
          last_x = x_m;
          return;
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL exit_timeout: obstacle did not exit within 1000 ticks");
      return;
    end
    last_x = x_m;
    model_pass();
    $display("obstacle sel=%b w=%0d exited after %0d ticks at x=%0d, speed now %0d",
             s, w, ticks, x_m, exp_speed);
    for (int g = 1; g <= GAP_TICKS; g++) begin
      @(negedge clk);
      checks++;
      if (bus.obstacle_req !== (g == GAP_TICKS) || bus.passed !== 1'b0) begin
        errors++;
        $display("FAIL gap: tick %0d req=%b passed=%b required req=%b passed=0",
                 g, bus.obstacle_req, bus.passed, (g == GAP_TICKS));
      end
    end
  endtask

  task automatic test_reset();
    int req_seen;
    rst           = 1'b1;
    bus.gamestate = 2'b00;
    bus.tick      = 1'b0;
    bus.sel_in    = 4'd0;
    bus.width_in  = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.obstacle_req !== 1'b0 || bus.obstacle_x !== 12'(SCREEN_W) || bus.obstacle_w !== 10'd0 ||
        bus.obstacle_sel !== 4'd0 || bus.obstacle_visible !== 1'b0 || bus.passed !== 1'b0 ||
        bus.speed !== 4'd4) begin
      errors++;
      $display("FAIL reset_values: req=%b x=%0d w=%0d sel=%b vis=%b passed=%b speed=%0d required 0 640 0 0 0 0 4",
               bus.obstacle_req, $signed(bus.obstacle_x), bus.obstacle_w, bus.obstacle_sel,
               bus.obstacle_visible, bus.passed, bus.speed);
    end
    req_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.obstacle_req !== 1'b0) req_seen++;
    end
    checks++;
    if (req_seen != 0) begin
      errors++;
      $display("FAIL idle_no_req: obstacle_req high in %0d cycles required 0", req_seen);
    end
    $display("reset: idle for 100 cycles");
  endtask

  task automatic test_first_obstacle();
    int ticks, lx;
    exp_speed = 4; exp_cnt = 0; exp_speed2 = 4; exp_cnt2 = 0;
    bus.tick      = 1'b1;
    bus.gamestate = 2'b01;
    @(negedge clk);
    do_obstacle(4'b0111, 10'd100, -1, ticks, lx);
    checks++;
    if (ticks != 185 || lx != -100) begin
      errors++;
      $display("FAIL first_exit_tick: ticks=%0d x=%0d required 185 and -100", ticks, lx);
    end
  endtask

  task automatic test_speed_step();
    int ticks, lx;
    logic [3:0] sels [4] = '{4'b0100, 4'b1000, 4'b0101, 4'b0110};
    logic [9:0] wids [4] = '{10'd30, 10'd50, 10'd0, 10'd120};
    for (int k = 0; k < 4; k++) do_obstacle(sels[k], wids[k], -1, ticks, lx);
    checks++;
    if (bus.speed !== 4'd5 || bus2.speed !== 4'd5) begin
      errors++;
      $display("FAIL speed_after_5: speed=%0d capped=%0d required 5 and 5", bus.speed, bus2.speed);
    end
    for (int k = 0; k < 5; k++) do_obstacle(sels[k % 4], wids[(k + 1) % 4], -1, ticks, lx);
    checks++;
    if (bus.speed !== 4'd6 || bus2.speed !== 4'd5) begin
      errors++;
      $display("FAIL speed_after_10: speed=%0d capped=%0d required 6 and 5", bus.speed, bus2.speed);
    end
  endtask

  task automatic test_freeze();
    int ticks, lx;
    do_obstacle(4'b1000, 10'd40, 300, ticks, lx);
    bus.gamestate = 2'b11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (bus.obstacle_x !== 12'(lx) || bus.obstacle_visible !== 1'b1 || bus.obstacle_sel !== 4'b1000 ||
          bus.obstacle_req !== 1'b0 || bus.passed !== 1'b0 || bus.speed !== 4'(exp_speed)) begin
        errors++;
        $display("FAIL frozen: x=%0d vis=%b sel=%b req=%b passed=%b speed=%0d required x=%0d vis=1 sel=1000 req=0 passed=0 speed=%0d",
                 $signed(bus.obstacle_x), bus.obstacle_visible, bus.obstacle_sel, bus.obstacle_req,
                 bus.passed, bus.speed, lx, exp_speed);
      end
    end
    bus.gamestate = 2'b01;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.obstacle_x !== 12'(lx) || bus.obstacle_visible !== 1'b1 || bus.obstacle_req !== 1'b0) begin
      errors++;
      $display("FAIL frozen_running: x=%0d vis=%b req=%b required x=%0d vis=1 req=0",
               $signed(bus.obstacle_x), bus.obstacle_visible, bus.obstacle_req, lx);
    end
    bus.gamestate = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.obstacle_x !== 12'(SCREEN_W) || bus.obstacle_visible !== 1'b0 || bus.speed !== 4'd4 ||
        bus2.speed !== 4'd4 || bus.obstacle_sel !== 4'b1000 || bus.obstacle_w !== 10'd40 ||
        bus.obstacle_req !== 1'b0) begin
      errors++;
      $display("FAIL unbegin: x=%0d vis=%b speed=%0d capped=%0d sel=%b w=%0d req=%b required 640 0 4 4 1000 40 0",
               $signed(bus.obstacle_x), bus.obstacle_visible, bus.speed, bus2.speed,
               bus.obstacle_sel, bus.obstacle_w, bus.obstacle_req);
    end
    exp_speed = 4; exp_cnt = 0; exp_speed2 = 4; exp_cnt2 = 0;
    $display("freeze: held x=%0d for 60 cycles, released to idle", lx);
  endtask

  task automatic test_reset_mid_req();
    int ticks, lx;
    bus.gamestate = 2'b01;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.obstacle_req !== 1'b1) begin
      errors++;
      $display("FAIL req_before_rst: obstacle_req=%b required 1", bus.obstacle_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.obstacle_req !== 1'b0 || bus2.obstacle_req !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_req: req=%b capped req=%b required 0", bus.obstacle_req, bus2.obstacle_req);
    end
    @(negedge clk);
    checks++;
    if (bus.obstacle_req !== 1'b0 || bus.obstacle_sel !== 4'd0 || bus.obstacle_w !== 10'd0 ||
        bus.obstacle_x !== 12'(SCREEN_W) || bus.speed !== 4'd4) begin
      errors++;
      $display("FAIL rst_hold: req=%b sel=%b w=%0d x=%0d speed=%0d required 0 0 0 640 4",
               bus.obstacle_req, bus.obstacle_sel, bus.obstacle_w, $signed(bus.obstacle_x), bus.speed);
    end
    rst = 1'b0;
    exp_speed = 4; exp_cnt = 0; exp_speed2 = 4; exp_cnt2 = 0;
    do_obstacle(4'b0100, 10'd0, -1, ticks, lx);
    checks++;
    if (ticks != 160 || lx != 0) begin
      errors++;
      $display("FAIL zero_width_exit: ticks=%0d x=%0d required 160 and 0", ticks, lx);
    end
  endtask

  initial begin
    test_reset();
    test_first_obstacle();
    test_speed_step();
    test_freeze();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
